systolic_tile_ctrl: RTL and testbench



---
 rtl/systolic_ctrl_pkg.sv | 16 +
 rtl/ctrl_phase_cnt.sv | 29 ++
 rtl/systolic_tile_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and defaults for the systolic tile sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD_W, SETTLE, CLEAR, COMPUTE, DRAIN, DONE
  } state_t;

  localparam int DEF_N_ROWS = 8;
  localparam int DEF_N_COLS = 8;

  // Cycles needed for the last activation to ripple out of the array.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/ctrl_phase_cnt.sv
// Loadable down-counter with enable; stops at zero and flags zero and one.
module ctrl_phase_cnt import systolic_ctrl_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Job sequencer for one weight-stationary systolic tile.
// Optional perf counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; k_len latched on accept
// LOAD_W  | one weight row per handshake, N_ROWS beats
// SETTLE  | N_COLS quiet cycles so load_weight reaches the last column
// CLEAR   | one-cycle accumulator clear
// COMPUTE | one MAC per accepted activation beat, k_len beats
// DRAIN   | zero activations pushed until results leave the array
// DONE    | one-cycle done / acc_valid strobe
module systolic_tile_ctrl import systolic_ctrl_pkg::*; #(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS,
  parameter int K_W    = 16,
  parameter int CNT_W  = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [K_W-1:0]                                k_len,
  output logic                                          busy,
  output logic                                          done,
  input  logic                                          w_valid,
  output logic                                          w_ready,
  output logic [(N_ROWS > 1 ? $clog2(N_ROWS) : 1)-1:0]  w_row_sel,
  output logic                                          pe_load_weight,
  output logic                                          pe_clr,
  input  logic                                          a_valid,
  output logic                                          a_ready,
  output logic                                          a_zero,
  output logic                                          pe_en,
  output logic                                          acc_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]                              perf_busy_cycles,
  output logic [CNT_W-1:0]                              perf_w_stall,
  output logic [CNT_W-1:0]                              perf_a_stall
`endif
);

  localparam int D_LEN  = drain_len(N_ROWS, N_COLS);
  localparam int PH_MAX = (N_COLS > D_LEN) ? N_COLS : D_LEN;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int RS_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  state_t          state_q, state_d;
  logic [RS_W-1:0] row_q;
  logic            start_acc, w_hs, a_hs, last_row;
  logic            ph_load, ph_en, ph_zero, ph_last;
  logic [PH_W-1:0] ph_val;
  logic            beat_zero, beat_last;

  assign start_acc = (state_q == IDLE) && start;
  assign w_hs      = w_valid && w_ready;
  assign a_hs      = a_valid && a_ready;
  assign last_row  = w_hs && (row_q == RS_W'(N_ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc || last_row) begin
        row_q <= '0;
      end else if (w_hs) begin
        row_q <= row_q + RS_W'(1);
      end
    end
  end

  // One timer serves both SETTLE and DRAIN; each phase loads it on entry.
  assign ph_load = last_row || (a_hs && beat_last);
  assign ph_val  = last_row ? PH_W'(N_COLS) : PH_W'(D_LEN);
  assign ph_en   = (state_q == SETTLE) || (state_q == DRAIN);

  ctrl_phase_cnt #(.W(PH_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .zero     (ph_zero),
    .last     (ph_last)
  );

  // The beat counter doubles as the latched k_len.
  ctrl_phase_cnt #(.W(K_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc),
    .load_val (k_len),
    .en       (a_hs),
    .zero     (beat_zero),
    .last     (beat_last)
  );

  always_comb begin
    state_d        = state_q;
    busy           = 1'b1;
    done           = 1'b0;
    acc_valid      = 1'b0;
    w_ready        = 1'b0;
    pe_load_weight = 1'b0;
    pe_clr         = 1'b0;
    a_ready        = 1'b0;
    a_zero         = 1'b0;
    pe_en          = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = LOAD_W;
      end
      LOAD_W: begin
        w_ready        = 1'b1;
        pe_load_weight = w_valid;
        if (last_row) state_d = SETTLE;
      end
      SETTLE: begin
        if (ph_last || ph_zero) state_d = CLEAR;
      end
      CLEAR: begin
        pe_clr  = 1'b1;
        state_d = beat_zero ? DONE : COMPUTE;
      end
      COMPUTE: begin
        a_ready = 1'b1;
        pe_en   = a_valid;
        if (a_hs && beat_last) state_d = (D_LEN > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        pe_en  = 1'b1;
        a_zero = 1'b1;
        if (ph_last || ph_zero) state_d = DONE;
      end
      DONE: begin
        done      = 1'b1;
        acc_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign w_row_sel = row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_w_stall     <= '0;
      perf_a_stall     <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        perf_busy_cycles <= '0;
        perf_w_stall     <= '0;
        perf_a_stall     <= '0;
      end
    end else begin
      if (perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + CNT_W'(1);
      if (state_q == LOAD_W && !w_valid && perf_w_stall != '1)
        perf_w_stall <= perf_w_stall + CNT_W'(1);
      if (state_q == COMPUTE && !a_valid && perf_a_stall != '1)
        perf_a_stall <= perf_a_stall + CNT_W'(1);
    end
  end
`else
  // Counter width only matters with the perf block; still reject a nonsense config.
  a_cnt_w_legal: assert property (@(posedge clk) CNT_W > 0);
`endif

  a_no_load_and_en: assert property (@(posedge clk) disable iff (rst) !(pe_load_weight && pe_en));
  a_no_clr_and_en:  assert property (@(posedge clk) disable iff (rst) !(pe_clr && pe_en));
  a_one_ready:      assert property (@(posedge clk) disable iff (rst) !(w_ready && a_ready));
  a_done_pulse:     assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Randomized scoreboard bench for systolic_tile_ctrl with a job-level timing model.
module tb_systolic_tile_ctrl;

  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int K_W    = 16;
  localparam int CNT_W  = 32;
  localparam int D_LEN  = N_ROWS + N_COLS - 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           w_valid = 1'b0;
  logic           a_valid = 1'b0;
  logic [K_W-1:0] k_len = '0;
  logic           busy, done, w_ready, pe_load_weight, pe_clr;
  logic           a_ready, a_zero, pe_en, acc_valid;
  logic [1:0]     w_row_sel;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_busy_cycles, perf_w_stall, perf_a_stall;
`endif

  systolic_tile_ctrl #(.N_ROWS(N_ROWS), .N_COLS(N_COLS), .K_W(K_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_len          (k_len),
    .busy           (busy),
    .done           (done),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_row_sel      (w_row_sel),
    .pe_load_weight (pe_load_weight),
    .pe_clr         (pe_clr),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_zero         (a_zero),
    .pe_en          (pe_en),
    .acc_valid      (acc_valid)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_w_stall     (perf_w_stall),
    .perf_a_stall     (perf_a_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int lat;
    int k;
  } exp_t;
  exp_t exp_q[$];

  // Current job plan: stall cycles inserted before each weight / activation beat.
  int gw[N_ROWS];
  int ga[$];
  int wi, wgap, ai, agap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Job latency from the accepting IDLE cycle to the done cycle.
  task automatic set_plan(input int k);
    int sw, sa;
    exp_t e;
    sw = 0;
    sa = 0;
    foreach (gw[i]) sw += gw[i];
    foreach (ga[i]) sa += ga[i];
    e.k   = k;
    e.lat = N_ROWS + sw + N_COLS + 1 + ((k > 0) ? (k + sa + D_LEN) : 0) + 1;
    exp_q.push_back(e);
    k_len = K_W'(k);
    wi    = 0;
    wgap  = gw[0];
    ai    = 0;
    agap  = (ga.size() > 0) ? ga[0] : 0;
  endtask

  // Driver: follows the plan while ready, otherwise drives junk valids.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (w_ready) begin
        if (wgap > 0) begin
          w_valid = 1'b0;
          wgap--;
        end else begin
          w_valid = 1'b1;
          wi++;
          wgap = (wi < N_ROWS) ? gw[wi] : 0;
        end
      end else begin
        w_valid = 1'($urandom_range(0, 1));
      end
      if (a_ready) begin
        if (agap > 0) begin
          a_valid = 1'b0;
          agap--;
        end else begin
          a_valid = 1'b1;
          ai++;
          agap = (ai < ga.size()) ? ga[ai] : 0;
        end
      end else begin
        a_valid = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor / scoreboard.
  int s_cyc = 0, busy_n = 0, ld_n = 0, clr_n = 0, en_n = 0, az_n = 0, done_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_n = 0; ld_n = 0; clr_n = 0; en_n = 0; az_n = 0;
      end else begin
        check("invariants", {61'd0, pe_load_weight & pe_en, pe_clr & pe_en, w_ready & a_ready}, 64'd0);
        if (start && !busy) begin
          s_cyc = cyc;
          busy_n = 0; ld_n = 0; clr_n = 0; en_n = 0; az_n = 0;
        end
        if (busy) busy_n++;
        if (pe_load_weight) begin
          check("w_row_sel", 64'(w_row_sel), 64'(ld_n));
          ld_n++;
        end
        if (pe_clr) clr_n++;
        if (pe_en)  en_n++;
        if (a_zero) az_n++;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_latency", 64'(cyc - s_cyc), 64'(e.lat));
            check("load_beats", 64'(ld_n), 64'(N_ROWS));
            check("clr_cycles", 64'(clr_n), 64'd1);
            check("en_cycles", 64'(en_n), 64'((e.k > 0) ? e.k + D_LEN : 0));
            check("a_zero_cycles", 64'(az_n), 64'((e.k > 0) ? D_LEN : 0));
            check("busy_cycles", 64'(busy_n), 64'(e.lat));
            check("acc_valid", 64'(acc_valid), 64'd1);
`ifdef SYSTOLIC_CTRL_PERF_EN
            check("perf_busy", 64'(perf_busy_cycles), 64'(e.lat - 1));
`endif
          end
        end
      end
    end
  end

  // Runs one job; returns in its DONE cycle. acc is the accepting IDLE cycle.
  task automatic do_job(input int k, input bit keep, input int gap, output int acc);
    int n;
    set_plan(k);
    acc = -1;
    if (!start) begin
      repeat (gap) begin @(posedge clk); #1; end
      start = 1'b1;
    end
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1; n++;
      if (busy) break;
    end
    if (!busy) begin
      check("start_accept_timeout", 64'd0, 64'd1);
      start = 1'b0;
      return;
    end
    acc = cyc - 1;
    if (!keep) start = 1'b0;
    k_len = K_W'($urandom);
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1; n++;
      if (done) break;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int acc, d, d0, n;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {53'd0, busy, done, w_ready, pe_load_weight, pe_clr,
                            a_ready, a_zero, pe_en, acc_valid, w_row_sel}, 64'd0);
    rst = 1'b0;

    gw = '{default: 0}; ga = {0, 0, 0};
    do_job(3, 1'b0, 1, acc);
    gw = '{default: 1}; ga = {0, 0, 0};
    do_job(3, 1'b0, 1, acc);
    gw = '{default: 0}; ga = {0, 2, 0};
    do_job(3, 1'b0, 1, acc);
    ga.delete();
    do_job(0, 1'b0, 1, acc);
    gw = '{default: 2}; ga = {3};
    do_job(1, 1'b0, 0, acc);

    // Reset in the middle of COMPUTE.
    gw = '{default: 0}; ga = {0, 0, 0, 0, 0};
    set_plan(5);
    start = 1'b1;
    n = 0;
    while (n < 10) begin @(posedge clk); #1; n++; if (busy) break; end
    start = 1'b0;
    n = 0;
    while (n < 100) begin @(posedge clk); #1; n++; if (a_ready) break; end
    check("reached_compute", 64'(a_ready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {53'd0, busy, done, w_ready, pe_load_weight, pe_clr,
                                  a_ready, a_zero, pe_en, acc_valid, w_row_sel}, 64'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_cnt), 64'(d0));
    ga = {0, 0, 0};
    do_job(3, 1'b0, 0, acc);

    // start held high across a job: next job accepted right after DONE.
    ga = {0, 0, 0};
    do_job(3, 1'b1, 0, acc);
    d = cyc;
    ga = {0, 0};
    do_job(2, 1'b0, 0, acc);
    check("held_start_restart", 64'(acc), 64'(d + 1));

    for (int j = 0; j < 1000; j++) begin
      int k;
      foreach (gw[i]) gw[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      k = $urandom_range(0, 7);
      ga.delete();
      for (int b = 0; b < k; b++) ga.push_back(($urandom_range(0, 3) == 0) ? 1 : 0);
      do_job(k, (j < 999) && ($urandom_range(0, 1) == 1), $urandom_range(0, 2), acc);
    end

    repeat (5) @(posedge clk);
    #1;
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
